// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus of the boot loader, plus loader status and FSM state.
interface imem_loader_if #(
    parameter int ADDR_W = 32
);
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wd;
    logic              core_srst;
    logic              done;
    logic              error;
    logic [2:0]        fsm_state;

    // Byte stream: a byte transfers on a rising edge where byte_valid && byte_ready;
    // the source must hold byte_data stable while byte_valid is high and not yet accepted.
    modport slave (
        input  start, byte_valid, byte_data,
        output byte_ready, imem_we, imem_addr, imem_wd, core_srst, done, error, fsm_state
    );

    modport master (
        output start, byte_valid, byte_data,
        input  byte_ready, imem_we, imem_addr, imem_wd, core_srst, done, error, fsm_state
    );
endinterface

// File: rtl/imem_loader.sv
// Byte-serial boot loader: length-prefixed LE image -> 32-bit imem writes, core held until loaded.
// Optional trailing checksum word enabled by defining CHECKSUM_EN.
module imem_loader #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    imem_loader_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
`ifdef CHECKSUM_EN
        , CHK = 3'd6
`endif
    } state_t;

`ifdef CHECKSUM_EN
    localparam state_t END_STATE = CHK;
`else
    localparam state_t END_STATE = DONE;
`endif

    state_t            state;
    state_t            next_state;
    logic              byte_ready_q;
    logic              ready_next;
    logic              accept;
    logic              last_byte;
    logic [1:0]        cnt;
    logic [31:0]       shreg;
    logic [31:0]       assembled;
    logic [IDX_W-1:0]  word_idx;
    logic [IDX_W-1:0]  len;
    logic              imem_we_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [31:0]       imem_wd_q;
`ifdef CHECKSUM_EN
    logic [31:0]       sum;
`endif

    assign accept    = bus.byte_valid && byte_ready_q;
    assign last_byte = accept && (cnt == 2'd3);
    // Bytes shift in from the top, so after four of them the first one sits in [7:0].
    assign assembled = {bus.byte_data, shreg[31:8]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ready_next = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) next_state = LEN;
            end
            LEN: begin
                if (last_byte) begin
                    if (assembled == 32'd0) begin
                        next_state = END_STATE;
                    end else if (assembled > 32'(DEPTH)) begin
                        next_state = ERR;
                    end else begin
                        next_state = DATA;
                    end
                end
            end
            DATA: begin
                if (last_byte) next_state = WRITE;
            end
            WRITE: begin
                if (word_idx + IDX_W'(1) == len) begin
                    next_state = END_STATE;
                end else begin
                    next_state = DATA;
                end
            end
`ifdef CHECKSUM_EN
            CHK: begin
                if (last_byte) next_state = (assembled == sum) ? DONE : ERR;
            end
`endif
            DONE, ERR: begin
                if (bus.start) next_state = LEN;
            end
            default: next_state = IDLE;
        endcase
        ready_next = (next_state == LEN) || (next_state == DATA);
`ifdef CHECKSUM_EN
        if (next_state == CHK) ready_next = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_ready_q <= 1'b0;
            cnt          <= 2'd0;
            shreg        <= 32'd0;
            word_idx     <= '0;
            len          <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wd_q    <= 32'd0;
`ifdef CHECKSUM_EN
            sum          <= 32'd0;
`endif
        end else begin
            byte_ready_q <= ready_next;
            imem_we_q    <= 1'b0;
            if (bus.start && (state == IDLE || state == DONE || state == ERR)) begin
                cnt      <= 2'd0;
                word_idx <= '0;
                len      <= '0;
`ifdef CHECKSUM_EN
                sum      <= 32'd0;
`endif
            end
            if (accept) begin
                shreg <= assembled;
                cnt   <= cnt + 2'd1;
            end
            if (state == LEN && last_byte) begin
                len <= IDX_W'(assembled);
            end
            if (state == DATA && last_byte) begin
                imem_we_q   <= 1'b1;
                imem_addr_q <= ADDR_W'({word_idx, 2'b00});
                imem_wd_q   <= assembled;
            end
            if (state == WRITE) begin
                word_idx <= word_idx + IDX_W'(1);
`ifdef CHECKSUM_EN
                sum      <= sum + imem_wd_q;
`endif
            end
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wd    = imem_wd_q;
    assign bus.done       = (state == DONE);
    assign bus.error      = (state == ERR);
    assign bus.core_srst  = (state != DONE);
    assign bus.fsm_state  = state;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: image-level model of expected writes and final status.
module tb_imem_loader;
  localparam int DEPTH = 1024;

  logic clk;
  logic rst_n;
  imem_loader_if #(.ADDR_W(32)) bus ();

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int checks = 0;
  int passes = 0;
  int wr_count = 0;
  int base;
  logic [31:0] last_addr = 0;
  logic [31:0] last_wd = 0;
  logic [63:0] exp_q[$];
  logic [31:0] img_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endfunction

  // compare process: every write against the model, plus status invariants
  always @(negedge clk) begin
    if (rst_n) begin
      check("srst_vs_done", 64'(bus.core_srst), 64'(!bus.done));
      check("done_error_excl", 64'(bus.done && bus.error), 64'(0));
      if (bus.imem_we) begin
        wr_count++;
        last_addr = bus.imem_addr;
        last_wd = bus.imem_wd;
        check("write_ready_low", 64'(bus.byte_ready), 64'(0));
        check("write_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) check("write_addr_data", {bus.imem_addr, bus.imem_wd}, exp_q.pop_front());
      end
    end
  end

  // driver tasks (called #1 after a rising edge)
  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int g;
    int n;
    g = gaps ? int'($urandom_range(0, 2)) : 0;
    if (g > 0) begin
      bus.byte_valid = 1'b0;
      repeat (g) @(posedge clk);
      #1;
    end
    bus.byte_valid = 1'b1;
    bus.byte_data = b;
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (bus.byte_ready) break;
      n++;
    end
    if (n >= 50) begin
      check("byte_accept_timeout", 64'(bus.byte_ready), 64'(1));
    end
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
  endtask

  // First byte of each word is sent back-to-back, so valid stays high through WRITE.
  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps && (k != 0));
  endtask

  task automatic run_image(input bit gaps, input bit bad_sum, input bit mid_start);
    logic [31:0] sum;
    sum = 32'd0;
    pulse_start();
    send_word(32'(img_q.size()), gaps);
    if (mid_start) pulse_start();
    foreach (img_q[i]) begin
      exp_q.push_back({32'(i * 4), img_q[i]});
      sum = sum + img_q[i];
      send_word(img_q[i], gaps);
    end
`ifdef CHECKSUM_EN
    send_word(sum + 32'(bad_sum), gaps);
`else
    if (bad_sum) sum = sum + 32'd1;
`endif
  endtask

  task automatic wait_end(input bit exp_done, input string tag);
    int n;
    n = 0;
    while (!(bus.done || bus.error) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 64'(n < 100), 64'(1));
    @(negedge clk);
    check({tag, "_done"}, 64'(bus.done), 64'(exp_done));
    check({tag, "_error"}, 64'(bus.error), 64'(!exp_done));
    check({tag, "_core_srst"}, 64'(bus.core_srst), 64'(!exp_done));
    check({tag, "_ready"}, 64'(bus.byte_ready), 64'(0));
    check({tag, "_writes_left"}, 64'(exp_q.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_byte_ready"}, 64'(bus.byte_ready), 64'(0));
    check({tag, "_imem_we"}, 64'(bus.imem_we), 64'(0));
    check({tag, "_imem_addr"}, 64'(bus.imem_addr), 64'(0));
    check({tag, "_imem_wd"}, 64'(bus.imem_wd), 64'(0));
    check({tag, "_core_srst"}, 64'(bus.core_srst), 64'(1));
    check({tag, "_done"}, 64'(bus.done), 64'(0));
    check({tag, "_error"}, 64'(bus.error), 64'(0));
  endtask

  initial begin
    bus.start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", 64'(bus.byte_ready), 64'(0));
    check("idle_core_srst", 64'(bus.core_srst), 64'(1));

    // 1: two-word image, start during DATA must be ignored
    base = wr_count;
    img_q = '{32'h00500093, 32'h00100113};
    run_image(1'b0, 1'b0, 1'b1);
`ifndef CHECKSUM_EN
    @(negedge clk);
    check("t1_last_we", 64'(bus.imem_we), 64'(1));
    check("t1_not_done_in_write", 64'(bus.done), 64'(0));
    @(negedge clk);
    check("t1_done_next", 64'(bus.done), 64'(1));
    check("t1_core_released", 64'(bus.core_srst), 64'(0));
    @(posedge clk); #1;
`endif
    wait_end(1'b1, "t1");
    check("t1_count", 64'(wr_count - base), 64'(2));
    check("t1_last_addr", 64'(last_addr), 64'h4);
    check("t1_last_wd", 64'(last_wd), 64'h00100113);

    // 2: zero-length image
    base = wr_count;
    pulse_start();
    check("t2_core_held", 64'(bus.core_srst), 64'(1));
    send_word(32'd0, 1'b0);
`ifdef CHECKSUM_EN
    send_word(32'd0, 1'b0);
`else
    @(negedge clk);
    check("t2_done_after_hdr", 64'(bus.done), 64'(1));
    @(posedge clk); #1;
`endif
    wait_end(1'b1, "t2");
    check("t2_no_writes", 64'(wr_count - base), 64'(0));

    // 3: length DEPTH+1 is rejected
    base = wr_count;
    pulse_start();
    send_word(32'(DEPTH + 1), 1'b0);
    @(negedge clk);
    check("t3_error", 64'(bus.error), 64'(1));
    check("t3_core_srst", 64'(bus.core_srst), 64'(1));
    check("t3_ready", 64'(bus.byte_ready), 64'(0));
    check("t3_done", 64'(bus.done), 64'(0));
    repeat (5) @(negedge clk);
    check("t3_no_writes", 64'(wr_count - base), 64'(0));
    check("t3_error_holds", 64'(bus.error), 64'(1));
    @(posedge clk); #1;

    // 4: three words with random valid gaps, restarting from ERR
    base = wr_count;
    img_q = '{32'hDEADBEEF, 32'h12345678, 32'h80000001};
    run_image(1'b1, 1'b0, 1'b0);
    wait_end(1'b1, "t4");
    check("t4_count", 64'(wr_count - base), 64'(3));
    check("t4_last_addr", 64'(last_addr), 64'h8);
    check("t4_last_wd", 64'(last_wd), 64'h80000001);

    // 5: reset in the middle of word 1, then a clean load
    pulse_start();
    send_word(32'd2, 1'b0);
    exp_q.push_back({32'h0, 32'hA5A50001});
    send_word(32'hA5A50001, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("t5_async");
    check("t5_writes_left", 64'(exp_q.size()), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    base = wr_count;
    img_q = '{32'hCAFEF00D, 32'h0000_0073};
    run_image(1'b0, 1'b0, 1'b0);
    wait_end(1'b1, "t5");
    check("t5_count", 64'(wr_count - base), 64'(2));
    check("t5_last_wd", 64'(last_wd), 64'h00000073);

`ifdef CHECKSUM_EN
    // 6: checksum match, mismatch, then recovery
    img_q = '{32'h00000013};
    run_image(1'b0, 1'b0, 1'b0);
    wait_end(1'b1, "t6_good");
    run_image(1'b0, 1'b1, 1'b0);
    wait_end(1'b0, "t6_bad");
    run_image(1'b0, 1'b0, 1'b0);
    wait_end(1'b1, "t6_recover");
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
